// File: rtl/vec_compare_ctrl_if.sv
// Command, compare-datapath and result signals of vec_compare_ctrl, bundled as one interface.
// The master side is the environment; the slave side is the controller.
`ifndef MAX_VLEN
`define MAX_VLEN 512
`endif

interface vec_compare_ctrl_if #(
   parameter int unsigned VLEN = `MAX_VLEN
);
   localparam int unsigned VL_W = $clog2(VLEN / 8) + 1;

   logic            start_valid;
   logic            start_ready;
   logic [2:0]      cmp_op;
   logic [1:0]      sew;
   logic [VL_W-1:0] vl;
   logic            vm;
   logic [VLEN-1:0] data_a;
   logic [VLEN-1:0] data_b;
   logic [VLEN-1:0] v0_mask;
   logic [VLEN-1:0] vd_old;
   logic [VLEN-1:0] cu_data_a;
   logic [VLEN-1:0] cu_data_b;
   logic [2:0]      cu_op;
   logic [1:0]      cu_sew;
   logic [VLEN-1:0] cu_result;
   logic            result_valid;
   logic            result_ready;
   logic [VLEN-1:0] mask_result;
   logic            busy;
   logic            err_sew;

   modport master (
      output start_valid, cmp_op, sew, vl, vm, data_a, data_b, v0_mask, vd_old,
      output cu_result, result_ready,
      input  start_ready, cu_data_a, cu_data_b, cu_op, cu_sew, result_valid, mask_result,
      input  busy, err_sew
   );

   modport slave (
      input  start_valid, cmp_op, sew, vl, vm, data_a, data_b, v0_mask, vd_old,
      input  cu_result, result_ready,
      output start_ready, cu_data_a, cu_data_b, cu_op, cu_sew, result_valid, mask_result,
      output busy, err_sew
   );
endinterface

// File: rtl/vec_compare_ctrl.sv
// Vector compare controller: latches a command, samples the external compare datapath once,
// then packs per-element results into a mask register EPC elements per cycle.
`ifndef MAX_VLEN
`define MAX_VLEN 512
`endif

module vec_compare_ctrl #(
   parameter int unsigned VLEN = `MAX_VLEN,
   parameter int unsigned EPC  = 8
) (
   input logic               clk,
   input logic               reset,
   vec_compare_ctrl_if.slave io_bus
);
   localparam int unsigned VL_W  = $clog2(VLEN / 8) + 1;
   localparam int unsigned IDX_W = VL_W + 1;
   localparam int unsigned BIT_W = $clog2(VLEN);

   typedef enum logic [1:0] {StIdle, StExec, StPack, StDone} state_e;

   state_e          r_state;
   logic            r_start_ready;
   logic            r_busy;
   logic            r_result_valid;
   logic            r_err_sew;
   logic [2:0]      r_op;
   logic [1:0]      r_sew;
   logic            r_vm;
   logic [VL_W-1:0] r_vl_eff;
   logic [IDX_W-1:0] r_idx;
   logic [VLEN-1:0] r_data_a;
   logic [VLEN-1:0] r_data_b;
   logic [VLEN-1:0] r_v0_mask;
   logic [VLEN-1:0] r_vd_old;
   logic [VLEN-1:0] r_cmp_reg;
   logic [VLEN-1:0] r_mask_result;

   logic [VL_W-1:0]  w_vlmax;
   logic [VL_W-1:0]  w_vl_eff;
   logic [VLEN-1:0]  w_pack_mask;
   logic [IDX_W-1:0] w_elem;
   logic [BIT_W-1:0] w_pos;
   logic             w_pack_last;

   // VLMAX = VLEN/SEW = (VLEN/8) >> sew
   always_comb begin
      w_vlmax  = VL_W'(VLEN / 8) >> io_bus.sew;
      w_vl_eff = (io_bus.vl > w_vlmax) ? w_vlmax : io_bus.vl;
   end

   always_comb begin
      w_pack_mask = r_mask_result;
      w_elem      = '0;
      w_pos       = '0;
      for (int unsigned e = 0; e < EPC; e++) begin
         w_elem = r_idx + IDX_W'(e);
         if (w_elem < IDX_W'(r_vl_eff)) begin
            w_pos = BIT_W'({w_elem, 3'b000} << r_sew);
            w_pack_mask[BIT_W'(w_elem)] = (r_vm || r_v0_mask[BIT_W'(w_elem)]) ?
                                          r_cmp_reg[w_pos] : r_vd_old[BIT_W'(w_elem)];
         end
      end
      w_pack_last = (r_idx + IDX_W'(EPC)) >= IDX_W'(r_vl_eff);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= StIdle;
         r_start_ready  <= 1'b1;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_err_sew      <= 1'b0;
         r_op           <= '0;
         r_sew          <= '0;
         r_vm           <= 1'b0;
         r_vl_eff       <= '0;
         r_idx          <= '0;
         r_data_a       <= '0;
         r_data_b       <= '0;
         r_v0_mask      <= '0;
         r_vd_old       <= '0;
         r_cmp_reg      <= '0;
         r_mask_result  <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.start_valid && r_start_ready) begin
                  r_op          <= io_bus.cmp_op;
                  r_sew         <= io_bus.sew;
                  r_vm          <= io_bus.vm;
                  r_vl_eff      <= w_vl_eff;
                  r_data_a      <= io_bus.data_a;
                  r_data_b      <= io_bus.data_b;
                  r_v0_mask     <= io_bus.v0_mask;
                  r_vd_old      <= io_bus.vd_old;
                  // Tail and masked-off bits start as vd_old and are never rewritten.
                  r_mask_result <= io_bus.vd_old;
                  r_start_ready <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= StExec;
               end
            end
            StExec: begin
               r_cmp_reg <= io_bus.cu_result;
               r_idx     <= '0;
               if (r_vl_eff == '0 || r_sew == 2'b11) begin
                  r_state        <= StDone;
                  r_result_valid <= 1'b1;
                  r_err_sew      <= (r_sew == 2'b11);
               end else begin
                  r_state <= StPack;
               end
            end
            StPack: begin
               r_mask_result <= w_pack_mask;
               r_idx         <= r_idx + IDX_W'(EPC);
               if (w_pack_last) begin
                  r_state        <= StDone;
                  r_result_valid <= 1'b1;
               end
            end
            StDone: begin
               if (io_bus.result_ready) begin
                  r_state        <= StIdle;
                  r_result_valid <= 1'b0;
                  r_err_sew      <= 1'b0;
                  r_busy         <= 1'b0;
                  r_start_ready  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign io_bus.start_ready  = r_start_ready;
   assign io_bus.busy         = r_busy;
   assign io_bus.result_valid = r_result_valid;
   assign io_bus.err_sew      = r_err_sew;
   assign io_bus.mask_result  = r_mask_result;
   assign io_bus.cu_data_a    = r_data_a;
   assign io_bus.cu_data_b    = r_data_b;
   assign io_bus.cu_op        = r_op;
   assign io_bus.cu_sew       = r_sew;
endmodule

// File: tb/tb_vec_compare_ctrl.sv
// Randomized bench for vec_compare_ctrl with a behavioural compare datapath and mask model.
module tb_vec_compare_ctrl;
   localparam int unsigned VLEN  = 512;
   localparam int unsigned EPC   = 8;
   localparam int unsigned VL_W  = $clog2(VLEN / 8) + 1;
   localparam int unsigned BIT_W = $clog2(VLEN);
   localparam int          NEL   = VLEN / 8;

   typedef struct {
      logic [2:0]      op;
      logic [1:0]      sew;
      logic [VL_W-1:0] vl;
      logic            vm;
      logic [VLEN-1:0] a;
      logic [VLEN-1:0] b;
      logic [VLEN-1:0] v0;
      logic [VLEN-1:0] vd;
   } cmd_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   vec_compare_ctrl_if #(.VLEN(VLEN)) vif ();

   vec_compare_ctrl #(.VLEN(VLEN), .EPC(EPC)) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (vif.slave)
   );

   function automatic logic [31:0] get_elem(input logic [VLEN-1:0] v, input int idx,
                                            input logic [1:0] sew);
      int          w;
      logic [31:0] r;
      w = 8 << sew;
      r = 32'(v >> (idx * w));
      if (w < 32) r = r & ((32'd1 << w) - 32'd1);
      return r;
   endfunction

   function automatic logic ref_cmp(input logic [2:0] op, input logic [1:0] sew,
                                    input logic [31:0] a, input logic [31:0] b);
      int     w;
      longint ua, ub, sa, sb;
      w  = 8 << sew;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[5'(w - 1)] ? ua - (longint'(1) << w) : ua;
      sb = b[5'(w - 1)] ? ub - (longint'(1) << w) : ub;
      case (op)
         3'd0:    return ua == ub;
         3'd1:    return ua != ub;
         3'd2:    return ua < ub;
         3'd3:    return ua <= ub;
         3'd4:    return sa < sb;
         3'd5:    return sa <= sb;
         3'd6:    return sa > sb;
         default: return ua > ub;
      endcase
   endfunction

   // Compare datapath: element e result lands in bit e*SEW.
   function automatic logic [VLEN-1:0] cu_model(input logic [2:0] op, input logic [1:0] sew,
                                                 input logic [VLEN-1:0] a,
                                                 input logic [VLEN-1:0] b);
      logic [VLEN-1:0] r;
      r = '0;
      if (sew != 2'b11)
         for (int e = 0; e < (NEL >> sew); e++)
            r[BIT_W'(e * (8 << sew))] = ref_cmp(op, sew, get_elem(a, e, sew),
                                                get_elem(b, e, sew));
      return r;
   endfunction

   always_comb vif.cu_result = cu_model(vif.cu_op, vif.cu_sew, vif.cu_data_a, vif.cu_data_b);

   function automatic int vl_eff_of(input cmd_t c);
      int vlmax;
      vlmax = NEL >> c.sew;
      return (int'(c.vl) < vlmax) ? int'(c.vl) : vlmax;
   endfunction

   function automatic logic [VLEN-1:0] ref_mask(input cmd_t c);
      logic [VLEN-1:0] m;
      m = c.vd;
      if (c.sew != 2'b11)
         for (int i = 0; i < vl_eff_of(c); i++)
            if (c.vm || c.v0[BIT_W'(i)])
               m[BIT_W'(i)] = ref_cmp(c.op, c.sew, get_elem(c.a, i, c.sew),
                                      get_elem(c.b, i, c.sew));
      return m;
   endfunction

   function automatic int ref_lat(input cmd_t c);
      int n;
      if (c.sew == 2'b11) return 2;
      n = vl_eff_of(c);
      if (n == 0) return 2;
      return 2 + (n + int'(EPC) - 1) / int'(EPC);
   endfunction

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.op  = 3'($urandom_range(0, 7));
      c.sew = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      c.vl  = VL_W'($urandom_range(0, (1 << VL_W) - 1));
      if ($urandom_range(0, 2) == 0) c.vl = VL_W'($urandom_range(0, 8));
      c.vm  = 1'($urandom_range(0, 1));
      c.a   = rand_vec();
      c.v0  = rand_vec();
      c.vd  = rand_vec();
      if ($urandom_range(0, 1) == 1) begin
         c.b = c.a;
         for (int i = 0; i < NEL; i++)
            if ($urandom_range(0, 3) == 0) c.b[i*8 +: 8] = 8'($urandom());
      end else begin
         c.b = rand_vec();
      end
      return c;
   endfunction

   task automatic drive_cmd(input cmd_t c);
      vif.cmp_op  = c.op;
      vif.sew     = c.sew;
      vif.vl      = c.vl;
      vif.vm      = c.vm;
      vif.data_a  = c.a;
      vif.data_b  = c.b;
      vif.v0_mask = c.v0;
      vif.vd_old  = c.vd;
   endtask

   // Issue c, scramble the inputs after acceptance, wait for result_valid (left pending).
   task automatic run_op(input cmd_t c, output int lat, output logic [VLEN-1:0] m,
                         output logic err, output logic to);
      @(negedge clk);
      drive_cmd(c);
      vif.start_valid = 1'b1;
      @(negedge clk);
      vif.start_valid = 1'b0;
      drive_cmd(rand_cmd());
      lat = 1;
      while (!vif.result_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      to  = !vif.result_valid;
      m   = vif.mask_result;
      err = vif.err_sew;
   endtask

   task automatic finish_result();
      vif.result_ready = 1'b1;
      @(negedge clk);
      vif.result_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      vif.start_valid = 1'b1;
      drive_cmd(rand_cmd());
      repeat (3) @(negedge clk);
      n_vec++; if (vif.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", vif.busy); end
      n_vec++; if (vif.result_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", vif.result_valid); end
      n_vec++; if (vif.err_sew !== 1'b0) begin n_miss++; $display("FAIL reset_err got %b want 0", vif.err_sew); end
      n_vec++; if (vif.mask_result !== '0) begin n_miss++; $display("FAIL reset_mask got %h want 0", vif.mask_result); end
      n_vec++; if (vif.cu_data_a !== '0 || vif.cu_op !== 3'd0) begin n_miss++; $display("FAIL reset_cu got op %0d a %h want 0", vif.cu_op, vif.cu_data_a); end
      vif.start_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (vif.start_ready !== 1'b1) begin n_miss++; $display("FAIL reset_start_ready got %b want 1", vif.start_ready); end
   endtask

   task automatic test_eq_sew8();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      c = rand_cmd();
      c.op = 3'd0; c.sew = 2'b00; c.vl = VL_W'(16); c.vm = 1'b1;
      c.b = c.a; c.b[3*8 +: 8] = ~c.a[3*8 +: 8]; c.vd = '1;
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != 4) begin n_miss++; $display("FAIL eq_latency got %0d want 4", lat); end
      n_vec++; if (m[15:0] !== 16'hFFF7) begin n_miss++; $display("FAIL eq_mask_low got %h want fff7", m[15:0]); end
      n_vec++; if (m[VLEN-1:16] !== '1) begin n_miss++; $display("FAIL eq_mask_tail got %h want all ones", m[VLEN-1:16]); end
      finish_result();
   endtask

   task automatic test_lt_masked();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      c = rand_cmd();
      c.op = 3'd4; c.sew = 2'b10; c.vl = VL_W'(16); c.vm = 1'b0;
      c.v0 = '0; c.v0[15:0] = 16'h00FF; c.vd = '0;
      for (int e = 0; e < 16; e++) begin
         c.a[e*32 +: 32] = 32'hFFFF_0000 + 32'(e);
         c.b[e*32 +: 32] = 32'(e);
      end
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != 4) begin n_miss++; $display("FAIL lt_latency got %0d want 4", lat); end
      n_vec++; if (m[15:0] !== 16'h00FF) begin n_miss++; $display("FAIL lt_mask_low got %h want 00ff", m[15:0]); end
      n_vec++; if (m[VLEN-1:16] !== '0) begin n_miss++; $display("FAIL lt_mask_tail got %h want 0", m[VLEN-1:16]); end
      finish_result();
   endtask

   task automatic test_vl_zero();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      c = rand_cmd();
      c.sew = 2'($urandom_range(0, 2)); c.vl = '0; c.vd = {NEL{8'hA5}};
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != 2) begin n_miss++; $display("FAIL vl0_latency got %0d want 2", lat); end
      n_vec++; if (m !== {NEL{8'hA5}}) begin n_miss++; $display("FAIL vl0_mask got %h want a5 pattern", m); end
      finish_result();
   endtask

   task automatic test_sew_illegal_and_clamp();
      cmd_t c; int lat; logic [VLEN-1:0] m, exp; logic err, to;
      c = rand_cmd();
      c.sew = 2'b11; c.vl = VL_W'(20);
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != 2) begin n_miss++; $display("FAIL sew11_latency got %0d want 2", lat); end
      n_vec++; if (m !== c.vd) begin n_miss++; $display("FAIL sew11_mask got %h want %h", m, c.vd); end
      n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL sew11_err got %b want 1", err); end
      finish_result();
      n_vec++; if (vif.err_sew !== 1'b0) begin n_miss++; $display("FAIL sew11_err_clear got %b want 0", vif.err_sew); end
      c = rand_cmd();
      c.op = 3'd0; c.sew = 2'b01; c.vl = VL_W'(100); c.vm = 1'b1; c.b = c.a; c.vd = '0;
      exp = '0; exp[31:0] = '1;
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != 6) begin n_miss++; $display("FAIL clamp_latency got %0d want 6", lat); end
      n_vec++; if (m !== exp) begin n_miss++; $display("FAIL clamp_mask got %h want %h", m, exp); end
      n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL clamp_err got %b want 0", err); end
      finish_result();
   endtask

   task automatic test_random();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      for (int n = 0; n < 40; n++) begin
         c = rand_cmd();
         run_op(c, lat, m, err, to);
         n_vec++; if (to || lat != ref_lat(c)) begin n_miss++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, ref_lat(c)); end
         n_vec++; if (m !== ref_mask(c)) begin n_miss++; $display("FAIL rand%0d_mask got %h want %h", n, m, ref_mask(c)); end
         n_vec++; if (err !== (c.sew == 2'b11)) begin n_miss++; $display("FAIL rand%0d_err got %b want %b", n, err, c.sew == 2'b11); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         finish_result();
      end
   endtask

   task automatic test_backpressure();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      int bad;
      c = rand_cmd();
      c.sew = 2'b00; c.vl = VL_W'(40);
      run_op(c, lat, m, err, to);
      n_vec++; if (to || m !== ref_mask(c)) begin n_miss++; $display("FAIL bp_mask got %h want %h", m, ref_mask(c)); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         drive_cmd(rand_cmd());
         vif.start_valid = 1'b1;
         @(negedge clk);
         if (vif.result_valid !== 1'b1 || vif.mask_result !== m || vif.start_ready !== 1'b0 ||
             vif.cu_data_a !== c.a) bad++;
      end
      n_vec++; if (bad != 0) begin n_miss++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
      vif.result_ready = 1'b1;
      @(negedge clk);
      vif.result_ready = 1'b0;
      vif.start_valid  = 1'b0;
      n_vec++; if (vif.busy !== 1'b0 || vif.result_valid !== 1'b0) begin n_miss++; $display("FAIL bp_exit got busy %b valid %b want 0 0", vif.busy, vif.result_valid); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      cmd_t c1, c2; int lat; logic [VLEN-1:0] m; logic err, to;
      c1 = rand_cmd();
      c2 = rand_cmd();
      c2.sew = 2'b01; c2.vl = VL_W'(24);
      run_op(c1, lat, m, err, to);
      drive_cmd(c2);
      vif.start_valid  = 1'b1;
      vif.result_ready = 1'b1;
      @(negedge clk);
      vif.result_ready = 1'b0;
      n_vec++; if (vif.busy !== 1'b0 || vif.start_ready !== 1'b1) begin n_miss++; $display("FAIL b2b_gap got busy %b ready %b want 0 1", vif.busy, vif.start_ready); end
      @(negedge clk);
      vif.start_valid = 1'b0;
      n_vec++; if (vif.busy !== 1'b1) begin n_miss++; $display("FAIL b2b_accept got busy %b want 1", vif.busy); end
      drive_cmd(rand_cmd());
      lat = 1;
      while (!vif.result_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      n_vec++; if (lat != ref_lat(c2)) begin n_miss++; $display("FAIL b2b_latency got %0d want %0d", lat, ref_lat(c2)); end
      n_vec++; if (vif.mask_result !== ref_mask(c2)) begin n_miss++; $display("FAIL b2b_mask got %h want %h", vif.mask_result, ref_mask(c2)); end
      finish_result();
   endtask

   task automatic test_reset_mid_pack();
      cmd_t c; int lat; logic [VLEN-1:0] m; logic err, to;
      int seen;
      c = rand_cmd();
      c.sew = 2'b00; c.vl = VL_W'(64); c.vm = 1'b1;
      @(negedge clk);
      drive_cmd(c);
      vif.start_valid = 1'b1;
      @(negedge clk);
      vif.start_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_vec++; if (vif.busy !== 1'b0 || vif.result_valid !== 1'b0 || vif.err_sew !== 1'b0) begin n_miss++; $display("FAIL rstpack_flags got busy %b valid %b err %b want 0 0 0", vif.busy, vif.result_valid, vif.err_sew); end
      n_vec++; if (vif.mask_result !== '0 || vif.cu_data_a !== '0 || vif.cu_data_b !== '0) begin n_miss++; $display("FAIL rstpack_data got mask %h want 0", vif.mask_result); end
      n_vec++; if (vif.start_ready !== 1'b1) begin n_miss++; $display("FAIL rstpack_ready got %b want 1", vif.start_ready); end
      reset = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (vif.result_valid !== 1'b0) seen++;
      end
      n_vec++; if (seen != 0) begin n_miss++; $display("FAIL rstpack_no_result got %0d valid cycles want 0", seen); end
      c = rand_cmd();
      run_op(c, lat, m, err, to);
      n_vec++; if (to || lat != ref_lat(c)) begin n_miss++; $display("FAIL rstpack_fresh_latency got %0d want %0d", lat, ref_lat(c)); end
      n_vec++; if (m !== ref_mask(c)) begin n_miss++; $display("FAIL rstpack_fresh_mask got %h want %h", m, ref_mask(c)); end
      finish_result();
   endtask

   initial begin
      vif.start_valid  = 1'b0;
      vif.result_ready = 1'b0;
      drive_cmd(rand_cmd());
      test_reset();
      test_eq_sew8();
      test_lt_masked();
      test_vl_zero();
      test_sew_illegal_and_clamp();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_pack();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
